inst_encoder_loader: RTL and testbench
======================================

Name: inst_encoder_loader

Overview:
Inverse of the ID stage decoder. Accepts field-level instruction descriptions and packs them into 32-bit RV32I words in R, I-load, I-imm, S, B or J format. Each legal word is written sequentially into instruction memory through a simple write port. Used by the testbench and boot loader to build programs that the fetch/ID path then reads back.

Parameters:
WORD_BITWIDTH, 32, instruction/data word width
REG_NUM_BITWIDTH, 5, register index width
ADDR_BITWIDTH, 10, instruction memory byte-address width
BASE_ADDR, 0, first write address, multiple of 4
DEPTH, 256, maximum words written before full
INST_R, 7'b0110011, R-type opcode
INST_I_LD, 7'b0000011, load opcode
INST_I_IMM, 7'b0010011, ALU-immediate opcode
INST_S, 7'b0100011, store opcode
INST_B, 7'b1100011, branch opcode
INST_J, 7'b1101111, JAL opcode

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
clr  input  1  synchronous restart: address/count/err cleared
in_valid  input  1  instruction fields valid
in_ready  output  1  encoder can accept
in_opcode  input  7  opcode
in_funct3  input  3  funct3
in_funct7  input  7  funct7 (R only)
in_rd  input  REG_NUM_BITWIDTH  destination reg
in_rs1  input  REG_NUM_BITWIDTH  source reg 1
in_rs2  input  REG_NUM_BITWIDTH  source reg 2
in_imm  input  WORD_BITWIDTH  signed byte-offset immediate, unencoded
mem_we  output  1  write strobe, one cycle per word
mem_addr  output  ADDR_BITWIDTH  byte address of write
mem_wdata  output  WORD_BITWIDTH  encoded word
count  output  $clog2(DEPTH+1)  words written since reset/clr
full  output  1  count == DEPTH
err  output  1  sticky: a rejected instruction was seen

Behaviour:
- Reset (async, rst=1): mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, count=0, full=0, err=0. in_ready is then 1.
- in_ready = !full && !clr (combinational).
- Handshake: an instruction is accepted on a rising edge with in_valid && in_ready. in_valid with in_ready=0 is held off; the source must hold its fields.
- Latency: the encoding is combinational from the inputs and registered on acceptance. mem_we=1 with mem_wdata in the cycle after acceptance; mem_addr is the address of that word.
- After each write, mem_addr advances by 4 and count by 1. mem_we deasserts unless a new word was accepted that cycle. Back-to-back acceptance gives one write per cycle.
- Encoding, with imm = in_imm:
  - R: funct7|rs2|rs1|funct3|rd|op. in_imm is ignored.
  - I_LD / I_IMM: imm[11:0]|rs1|funct3|rd|op.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|op.
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|op.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
- Rejection: an accepted instruction is rejected if any of these holds:
  - opcode not in the six above;
  - I/S: imm[31:11] not all equal;
  - B: imm[31:12] not all equal or imm[0]=1;
  - J: imm[31:20] not all equal or imm[0]=1.
- A rejected instruction is consumed with no write, and address/count are unchanged. err is set the cycle after and stays set until rst or clr. Later legal instructions are still written.
- full: set in the same cycle the DEPTH-th write is asserted; in_ready=0 from then on. No address wrap-around; writes never exceed BASE_ADDR+4*(DEPTH-1).
- clr: on the edge with clr=1, any pending write completes. Then mem_addr=BASE_ADDR, count=0, full=0, err=0. No acceptance occurs in that cycle. clr and in_valid together: clr wins and the input is not consumed.
- rst mid-write: the strobe drops immediately (asynchronous).

Test Plan:
- ADDI: opcode 0010011, rd=1, rs1=0, f3=0, imm=5 -> next cycle mem_we=1, mem_addr=0, mem_wdata=0x00500093, count=1.
- Back-to-back stream: add x3,x1,x2 (f7=0) -> 0x002081B3 at addr 0; sw x2,8(x1) (f3=010) -> 0x0020A423 at addr 4; beq x1,x2,-4 -> 0xFE208EE3 at addr 8; jal x1,2048 -> 0x001000EF at addr 12. All in 4 consecutive cycles, count=4.
- Rejection: ADDI with imm=2048, then a B-type with imm=3, then opcode 0110111 -> no mem_we, err=1, count unchanged; a following legal ADDI is still written at the next address.
- Full: DEPTH=4, 5 legal requests with in_valid held -> 4 writes at 0,4,8,12. full=1 with the 4th strobe, in_ready=0, the 5th is never consumed.
- clr with in_valid=1 after 3 writes and err=1 -> no acceptance that cycle. Then count=0, err=0, and the next ADDI is written at BASE_ADDR.
- Async reset asserted between edges while mem_we=1 -> mem_we, count, full and err go to 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/inst_encoder_loader.sv
// Packs field-level RV32I instruction descriptions into 32-bit words and
// streams the legal ones into instruction memory through a simple write port.
module inst_encoder_loader #(
   parameter int WORD_BITWIDTH    = 32,
   parameter int REG_NUM_BITWIDTH = 5,
   parameter int ADDR_BITWIDTH    = 10,
   parameter int BASE_ADDR        = 0,
   parameter int DEPTH            = 256,
   parameter logic [6:0] INST_R     = 7'b0110011,
   parameter logic [6:0] INST_I_LD  = 7'b0000011,
   parameter logic [6:0] INST_I_IMM = 7'b0010011,
   parameter logic [6:0] INST_S     = 7'b0100011,
   parameter logic [6:0] INST_B     = 7'b1100011,
   parameter logic [6:0] INST_J     = 7'b1101111
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clr,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [6:0]                    in_opcode,
   input  logic [2:0]                    in_funct3,
   input  logic [6:0]                    in_funct7,
   input  logic [REG_NUM_BITWIDTH-1:0]   in_rd,
   input  logic [REG_NUM_BITWIDTH-1:0]   in_rs1,
   input  logic [REG_NUM_BITWIDTH-1:0]   in_rs2,
   input  logic [WORD_BITWIDTH-1:0]      in_imm,
   output logic                          mem_we,
   output logic [ADDR_BITWIDTH-1:0]      mem_addr,
   output logic [WORD_BITWIDTH-1:0]      mem_wdata,
   output logic [$clog2(DEPTH+1)-1:0]    count,
   output logic                          full,
   output logic                          err
);

   localparam int CNT_W = $clog2(DEPTH+1);

   logic [WORD_BITWIDTH-1:0] enc;
   logic                     legal;
   logic                     accept;
   logic                     i_ok;
   logic                     b_ok;
   logic                     j_ok;

   assign in_ready = !full && !clr;
   assign accept   = in_valid && in_ready;

   // An immediate fits its field when every bit above the field is a copy of the sign bit.
   assign i_ok = (&in_imm[31:11]) || !(|in_imm[31:11]);
   assign b_ok = ((&in_imm[31:12]) || !(|in_imm[31:12])) && !in_imm[0];
   assign j_ok = ((&in_imm[31:20]) || !(|in_imm[31:20])) && !in_imm[0];

   always_comb begin
      enc   = '0;
      legal = 1'b0;
      case (in_opcode)
         INST_R: begin
            enc   = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            legal = 1'b1;
         end
         INST_I_LD, INST_I_IMM: begin
            enc   = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            legal = i_ok;
         end
         INST_S: begin
            enc   = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            legal = i_ok;
         end
         INST_B: begin
            enc   = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], in_opcode};
            legal = b_ok;
         end
         INST_J: begin
            enc   = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
            legal = j_ok;
         end
         default: begin
            enc   = '0;
            legal = 1'b0;
         end
      endcase
   end

   // mem_addr points at the word being written; it steps past a word once that
   // write completes, but never beyond the last slot so it cannot wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_we    <= 1'b0;
         mem_addr  <= ADDR_BITWIDTH'(BASE_ADDR);
         mem_wdata <= '0;
         count     <= '0;
         full      <= 1'b0;
         err       <= 1'b0;
      end else if (clr) begin
         mem_we   <= 1'b0;
         mem_addr <= ADDR_BITWIDTH'(BASE_ADDR);
         count    <= '0;
         full     <= 1'b0;
         err      <= 1'b0;
      end else begin
         mem_we <= 1'b0;
         if (mem_we && !full)
            mem_addr <= mem_addr + ADDR_BITWIDTH'(4);
         if (accept) begin
            if (legal) begin
               mem_we    <= 1'b1;
               mem_wdata <= enc;
               count     <= count + CNT_W'(1);
               full      <= (count == CNT_W'(DEPTH-1));
            end else begin
               err <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Directed self-checking bench for inst_encoder_loader, built with DEPTH=4 so
// the full condition is reachable in a short run.
module tb_inst_encoder_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        clr;
   logic        in_valid;
   logic        in_ready;
   logic [6:0]  in_opcode;
   logic [2:0]  in_funct3;
   logic [6:0]  in_funct7;
   logic [4:0]  in_rd;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic [31:0] in_imm;
   logic        mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [2:0]  count;
   logic        full;
   logic        err;

   int checks = 0;
   int errors = 0;

   inst_encoder_loader #(.DEPTH(4)) dut (
      .clk(clk), .rst(rst), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
      .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .count(count), .full(full), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm);
      in_valid  = 1'b1;
      in_opcode = op;
      in_funct3 = f3;
      in_funct7 = f7;
      in_rd     = rd;
      in_rs1    = rs1;
      in_rs2    = rs2;
      in_imm    = imm;
   endtask

   task automatic write_check(input string tag, input logic [9:0] addr, input logic [31:0] word,
                              input logic [2:0] cnt);
      check({tag, "_we"}, 32'(mem_we), 32'd1);
      check({tag, "_addr"}, 32'(mem_addr), 32'(addr));
      check({tag, "_wdata"}, mem_wdata, word);
      check({tag, "_count"}, 32'(count), 32'(cnt));
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; in_valid = 1'b0;
      in_opcode = '0; in_funct3 = '0; in_funct7 = '0;
      in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
      #12;
      check("rst_we", 32'(mem_we), 32'd0);
      check("rst_addr", 32'(mem_addr), 32'd0);
      check("rst_wdata", mem_wdata, 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_full", 32'(full), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_ready", 32'(in_ready), 32'd1);
      rst = 1'b0;
      tick();

      // addi x1, x0, 5
      drive(7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
      tick();
      in_valid = 1'b0;
      write_check("addi", 10'd0, 32'h00500093, 3'd1);
      tick();
      check("addi_we_drop", 32'(mem_we), 32'd0);
      clr = 1'b1;
      tick();
      clr = 1'b0;

      // back-to-back stream that also fills the DEPTH=4 memory
      drive(7'b0110011, 3'b000, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
      tick();
      write_check("add", 10'd0, 32'h002081B3, 3'd1);
      drive(7'b0100011, 3'b010, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
      tick();
      write_check("sw", 10'd4, 32'h0020A423, 3'd2);
      drive(7'b1100011, 3'b000, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC);
      tick();
      write_check("beq", 10'd8, 32'hFE208EE3, 3'd3);
      check("beq_full", 32'(full), 32'd0);
      drive(7'b1101111, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
      tick();
      write_check("jal", 10'd12, 32'h001000EF, 3'd4);
      check("jal_full", 32'(full), 32'd1);
      check("jal_ready", 32'(in_ready), 32'd0);
      drive(7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd9);
      tick();
      check("fifth_we", 32'(mem_we), 32'd0);
      tick();
      check("fifth_we2", 32'(mem_we), 32'd0);
      check("fifth_count", 32'(count), 32'd4);
      check("fifth_full", 32'(full), 32'd1);
      in_valid = 1'b0;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("clr_full", 32'(full), 32'd0);
      check("clr_count", 32'(count), 32'd0);

      // rejection: out-of-range I imm, odd B offset, unsupported opcode
      drive(7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
      tick();
      write_check("pre_rej", 10'd0, 32'h00500093, 3'd1);
      drive(7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
      tick();
      check("rej_i_we", 32'(mem_we), 32'd0);
      check("rej_i_err", 32'(err), 32'd1);
      drive(7'b1100011, 3'b000, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3);
      tick();
      check("rej_b_we", 32'(mem_we), 32'd0);
      drive(7'b0110111, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0);
      tick();
      check("rej_op_we", 32'(mem_we), 32'd0);
      check("rej_count", 32'(count), 32'd1);
      drive(7'b0010011, 3'b000, 7'd0, 5'd2, 5'd1, 5'd0, 32'hFFFFFFFF);
      tick();
      // addi x2, x1, -1
      write_check("post_rej", 10'd4, 32'hFFF08113, 3'd2);
      check("post_rej_err", 32'(err), 32'd1);
      drive(7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
      tick();
      write_check("third", 10'd8, 32'h00500093, 3'd3);

      // clr together with in_valid: clr wins, nothing consumed
      drive(7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd7);
      clr = 1'b1;
      #1;
      check("clr_ready", 32'(in_ready), 32'd0);
      tick();
      clr = 1'b0;
      check("clr2_we", 32'(mem_we), 32'd0);
      check("clr2_count", 32'(count), 32'd0);
      check("clr2_err", 32'(err), 32'd0);
      tick();
      in_valid = 1'b0;
      write_check("after_clr", 10'd0, 32'h00700093, 3'd1);

      // asynchronous reset while a write strobe is active
      drive(7'b0110111, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0);
      tick();
      drive(7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
      tick();
      in_valid = 1'b0;
      check("pre_arst_we", 32'(mem_we), 32'd1);
      check("pre_arst_err", 32'(err), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("arst_we", 32'(mem_we), 32'd0);
      check("arst_count", 32'(count), 32'd0);
      check("arst_full", 32'(full), 32'd0);
      check("arst_err", 32'(err), 32'd0);
      check("arst_addr", 32'(mem_addr), 32'd0);
      rst = 1'b0;
      tick();
      check("arst_ready", 32'(in_ready), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
